stream_demux_1_4: RTL and testbench

Registered 1-to-4 stream demultiplexer. It steers each word from one valid/ready upstream port into one of four downstream ports. Each output has its own one-entry holding register, so a stalled output does not block words bound for other outputs. It is the distribution counterpart of the 4:1 selector in the combinational library, and serves as the fan-out stage in front of per-lane consumers.

---
 rtl/stream_demux_1_4.sv | 101 ++++++++++
 tb/tb_stream_demux_1_4.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4 - registered 1-to-4 valid/ready stream demultiplexer.
//
// Each upstream word is steered into one of four one-entry holding registers.
// Each slot is independent, so a stalled consumer only blocks words that are
// bound for its own slot.
//
// Build option: define STREAM_DEMUX_RR_EN for round-robin mode. In that mode
// up_sel is ignored and an internal 2-bit pointer picks the target. The pointer
// starts at 0 and advances by one on every accepted word.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   up_valid/up_ready   upstream handshake
//   up_data [WIDTH]     upstream word
//   up_sel  [2]         destination index (ignored in round-robin mode)
//   dK_valid            slot K holds a word (K = 0..3)
//   dK_ready            consumer K takes the word this cycle
//   dK      [WIDTH]     slot K holding register

module stream_demux_1_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [1:0]       up_sel,
  output logic             d0_valid,
  output logic             d1_valid,
  output logic             d2_valid,
  output logic             d3_valid,
  input  logic             d0_ready,
  input  logic             d1_ready,
  input  logic             d2_ready,
  input  logic             d3_ready,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3
);

  logic [3:0]       valid_q;
  logic [3:0]       ready_vec;
  logic [WIDTH-1:0] data_q [4];
  logic [1:0]       tgt;
  logic             accept;

  assign ready_vec = {d3_ready, d2_ready, d1_ready, d0_ready};

`ifdef STREAM_DEMUX_RR_EN
  logic [1:0] rr_ptr;
  logic       unused_sel;

  assign unused_sel = ^up_sel;
  assign tgt        = rr_ptr;

  // The pointer moves only on an accepted word. It wraps naturally in 2 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= 2'd0;
    else if (accept)
      rr_ptr <= rr_ptr + 2'd1;
  end
`else
  assign tgt = up_sel;
`endif

  // A full target slot can still take a word if it is being drained this cycle.
  assign up_ready = !valid_q[tgt] | ready_vec[tgt];
  assign accept   = up_valid & up_ready;

  // A refill takes priority over a drain, so a full slot can be drained and
  // refilled in the same cycle without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 4'b0000;
      for (int k = 0; k < 4; k++)
        data_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (tgt == 2'(k))) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= up_data;
        end else if (valid_q[k] && ready_vec[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign d0_valid = valid_q[0];
  assign d1_valid = valid_q[1];
  assign d2_valid = valid_q[2];
  assign d3_valid = valid_q[3];
  assign d0       = data_q[0];
  assign d1       = data_q[1];
  assign d2       = data_q[2];
  assign d3       = data_q[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
module tb_stream_demux_1_4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up_valid = 1'b0;
  logic       up_ready;
  logic [3:0] up_data = 4'h0;
  logic [1:0] up_sel = 2'd0;
  logic [3:0] dr = 4'hf;
  logic [3:0] dv;
  logic [3:0] dd [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_demux_1_4 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_sel(up_sel),
    .d0_valid(dv[0]), .d1_valid(dv[1]), .d2_valid(dv[2]), .d3_valid(dv[3]),
    .d0_ready(dr[0]), .d1_ready(dr[1]), .d2_ready(dr[2]), .d3_ready(dr[3]),
    .d0(dd[0]), .d1(dd[1]), .d2(dd[2]), .d3(dd[3])
  );

  // Behavioural model: the slot contents and flags, plus the round-robin pointer.
  logic       m_valid [4];
  logic [3:0] m_data  [4];
  int         m_ptr;

  function automatic int m_target();
`ifdef STREAM_DEMUX_RR_EN
    return m_ptr;
`else
    return int'(up_sel);
`endif
  endfunction

  function automatic logic m_ready();
    int t = m_target();
    return !m_valid[t] || dr[t];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_valid[k] <= 1'b0;
        m_data[k]  <= 4'h0;
      end
      m_ptr <= 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (up_valid && m_ready() && m_target() == k) begin
          m_valid[k] <= 1'b1;
          m_data[k]  <= up_data;
        end else if (m_valid[k] && dr[k]) begin
          m_valid[k] <= 1'b0;
        end
      end
      if (up_valid && m_ready())
        m_ptr <= (m_ptr + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every cycle, check the DUT against the model on the falling edge.
  always @(negedge clk) begin
    check("model up_ready", {31'd0, up_ready}, {31'd0, m_ready()});
    for (int k = 0; k < 4; k++) begin
      check($sformatf("model d%0d_valid", k), {31'd0, dv[k]}, {31'd0, m_valid[k]});
      check($sformatf("model d%0d", k), {28'd0, dd[k]}, {28'd0, m_data[k]});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] s);
    up_valid = v;
    up_data  = d;
    up_sel   = s;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset up_ready", {31'd0, up_ready}, 32'd1);
    check("reset valids", {28'd0, dv}, 32'd0);
    check("reset d0", {28'd0, dd[0]}, 32'd0);
    check("reset d3", {28'd0, dd[3]}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Four words to four slots back to back, all consumers ready.
    dr = 4'hf;
    drive(1'b1, 4'ha, 2'd0);
    check("seq up_ready 0", {31'd0, up_ready}, 32'd1);
    cycle();
    check("seq d0", {27'd0, dv[0], dd[0]}, {27'd0, 1'b1, 4'ha});
    drive(1'b1, 4'hb, 2'd1);
    check("seq up_ready 1", {31'd0, up_ready}, 32'd1);
    cycle();
    check("seq d1", {27'd0, dv[1], dd[1]}, {27'd0, 1'b1, 4'hb});
    drive(1'b1, 4'hc, 2'd2);
    check("seq up_ready 2", {31'd0, up_ready}, 32'd1);
    cycle();
    check("seq d2", {27'd0, dv[2], dd[2]}, {27'd0, 1'b1, 4'hc});
    drive(1'b1, 4'hd, 2'd3);
    check("seq up_ready 3", {31'd0, up_ready}, 32'd1);
    cycle();
    check("seq d3", {27'd0, dv[3], dd[3]}, {27'd0, 1'b1, 4'hd});
    drive(1'b0, 4'h0, 2'd0);
    cycle();
    check("seq drained", {28'd0, dv}, 32'd0);

`ifndef STREAM_DEMUX_RR_EN
    // Stall slot 2, then send a word to slot 0 while it is stalled.
    dr[2] = 1'b0;
    drive(1'b1, 4'h3, 2'd2);
    cycle();
    check("stall d2 first", {27'd0, dv[2], dd[2]}, {27'd0, 1'b1, 4'h3});
    drive(1'b1, 4'h7, 2'd2);
    #1 check("stall up_ready", {31'd0, up_ready}, 32'd0);
    cycle();
    check("stall d2 held", {27'd0, dv[2], dd[2]}, {27'd0, 1'b1, 4'h3});
    drive(1'b0, 4'h7, 2'd2);
    cycle();
    drive(1'b1, 4'h5, 2'd0);
    #1 check("other slot up_ready", {31'd0, up_ready}, 32'd1);
    cycle();
    check("other slot d0", {27'd0, dv[0], dd[0]}, {27'd0, 1'b1, 4'h5});
    check("other slot d2 kept", {27'd0, dv[2], dd[2]}, {27'd0, 1'b1, 4'h3});
    drive(1'b1, 4'h7, 2'd2);
    #1 check("restall up_ready", {31'd0, up_ready}, 32'd0);
    dr[2] = 1'b1;
    #1 check("drain up_ready", {31'd0, up_ready}, 32'd1);
    cycle();
    check("no bubble d2", {27'd0, dv[2], dd[2]}, {27'd0, 1'b1, 4'h7});
    drive(1'b0, 4'h0, 2'd0);
    cycle();

    // X data passes through unchanged.
    drive(1'b1, 4'bxxxx, 2'd3);
    cycle();
    check("x d3 valid", {31'd0, dv[3]}, 32'd1);
    check("x d3 data", {28'd0, dd[3]}, {28'd0, 4'bxxxx});
    drive(1'b0, 4'h0, 2'd0);
    cycle();

    // Asynchronous reset mid-cycle with slots 1 and 2 full.
    dr = 4'b1001;
    drive(1'b1, 4'h6, 2'd1);
    cycle();
    drive(1'b1, 4'h9, 2'd2);
    cycle();
    drive(1'b0, 4'h0, 2'd0);
    check("pre-reset valids", {28'd0, dv}, 32'd6);
    #2 rst = 1'b1;
    #1;
    check("async valids", {28'd0, dv}, 32'd0);
    check("async d1", {28'd0, dd[1]}, 32'd0);
    check("async d2", {28'd0, dd[2]}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    dr = 4'hf;
    cycle();
`else
    // Round-robin: up_sel is ignored and the words land in slots 0..3 in order.
    dr = 4'b1110;
    drive(1'b1, 4'h1, 2'd3);
    cycle();
    check("rr d0", {27'd0, dv[0], dd[0]}, {27'd0, 1'b1, 4'h1});
    drive(1'b1, 4'h2, 2'd3);
    cycle();
    check("rr d1", {27'd0, dv[1], dd[1]}, {27'd0, 1'b1, 4'h2});
    drive(1'b1, 4'h3, 2'd3);
    cycle();
    check("rr d2", {27'd0, dv[2], dd[2]}, {27'd0, 1'b1, 4'h3});
    drive(1'b1, 4'h4, 2'd3);
    cycle();
    check("rr d3", {27'd0, dv[3], dd[3]}, {27'd0, 1'b1, 4'h4});
    drive(1'b1, 4'h5, 2'd3);
    #1 check("rr fifth stalls", {31'd0, up_ready}, 32'd0);
    cycle();
    check("rr d0 held", {27'd0, dv[0], dd[0]}, {27'd0, 1'b1, 4'h1});
    dr[0] = 1'b1;
    #1 check("rr fifth ready", {31'd0, up_ready}, 32'd1);
    cycle();
    check("rr fifth d0", {27'd0, dv[0], dd[0]}, {27'd0, 1'b1, 4'h5});
    drive(1'b0, 4'h0, 2'd0);
    cycle();
`endif

    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
